bus_command_controller: RTL and testbench

// - 8288-style bus controller. Sits upstream of the chipset bus arbiter/READY logic.
// - Decodes 8088 status S2..S0 into T-state sequenced ALE, DT/R, DEN and the

---
 rtl/bus_command_controller_pkg.sv | 43 ++++
 rtl/bus_command_controller_if.sv | 30 +++
 rtl/bus_command_controller_decoder.sv | 25 ++
 rtl/bus_command_controller.sv | 144 ++++++++++++++
 tb/tb_bus_command_controller.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bus_command_controller_pkg.sv
// Shared types for the 8288-style bus command controller: status codes,
// T-state encoding, strobe vector layout and the read-cycle classifier.
package bus_cmd_pkg;

  typedef enum logic [2:0] {
    BS_INTA    = 3'b000,
    BS_IOR     = 3'b001,
    BS_IOW     = 3'b010,
    BS_HALT    = 3'b011,
    BS_FETCH   = 3'b100,
    BS_MEMR    = 3'b101,
    BS_MEMW    = 3'b110,
    BS_PASSIVE = 3'b111
  } bus_status_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } bus_state_t;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;

  localparam int STB_W    = 5;
  localparam int STB_INTA = 0;
  localparam int STB_IOR  = 1;
  localparam int STB_IOW  = 2;
  localparam int STB_MEMR = 3;
  localparam int STB_MEMW = 4;

  typedef logic [STB_W-1:0] strobe_vec_t;

  // Reads and INTA turn the data transceiver toward the processor.
  function automatic logic is_read(input bus_status_t s);
    case (s)
      BS_INTA, BS_IOR, BS_FETCH, BS_MEMR: is_read = 1'b1;
      default:                            is_read = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_command_controller_if.sv
// Processor-side status inputs and chipset-side command outputs of the
// bus command controller, bundled with producer/consumer modports.
interface bus_command_controller_if;
  logic       cpu_clock_en;
  logic [2:0] processor_status;
  logic       address_enable_n;
  logic       address_latch_enable;
  logic       data_bus_direction;
  logic       data_enable;
  logic       io_read_n;
  logic       io_write_n;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       interrupt_acknowledge_n;
  logic       halted;

  modport master (
    output cpu_clock_en, processor_status, address_enable_n,
    input  address_latch_enable, data_bus_direction, data_enable,
    input  io_read_n, io_write_n, memory_read_n, memory_write_n,
    input  interrupt_acknowledge_n, halted
  );

  modport slave (
    input  cpu_clock_en, processor_status, address_enable_n,
    output address_latch_enable, data_bus_direction, data_enable,
    output io_read_n, io_write_n, memory_read_n, memory_write_n,
    output interrupt_acknowledge_n, halted
  );
endinterface

// File: rtl/bus_command_controller_decoder.sv
// Maps a latched bus status to its single command strobe (one-hot, active
// high) and flags whether the cycle moves data toward the processor.
module bus_status_decoder
  import bus_cmd_pkg::*;
(
  input  bus_status_t status_i,
  output strobe_vec_t strobe_o,
  output logic        read_o
);

  // One strobe per status code; HALT and PASSIVE drive none.
  always_comb begin
    strobe_o = '0;
    case (status_i)
      BS_INTA:          strobe_o[STB_INTA] = 1'b1;
      BS_IOR:           strobe_o[STB_IOR]  = 1'b1;
      BS_IOW:           strobe_o[STB_IOW]  = 1'b1;
      BS_FETCH, BS_MEMR: strobe_o[STB_MEMR] = 1'b1;
      BS_MEMW:          strobe_o[STB_MEMW] = 1'b1;
      default:          strobe_o = '0;
    endcase
    read_o = is_read(status_i);
  end

endmodule

// File: rtl/bus_command_controller.sv
// 8288-style bus controller: sequences ALE, DT/R, DEN and the command
// strobes through T1..T4 from the 8088 status lines.
module bus_command_controller
  import bus_cmd_pkg::*;
#(
  parameter bit ADVANCED_WRITE = 1'b0
) (
  input logic                      clock,
  input logic                      reset_n,
  bus_command_controller_if.slave  bus
);

  bus_state_t  state_q, state_d;
  bus_status_t cycle_q, cycle_d;
  logic        ale_q, ale_d;
  logic        dtr_q, dtr_d;
  logic        den_q, den_d;
  logic        halted_q, halted_d;
  strobe_vec_t strobe_n_q, strobe_n_d;

  bus_status_t status_s;
  logic        passive_s;
  strobe_vec_t dec_strobe_s;
  logic        dec_read_s;

  assign status_s  = bus_status_t'(bus.processor_status);
  assign passive_s = (bus.processor_status == STATUS_PASSIVE);

  // Decode the cycle type that will be current after the edge, so outputs
  // register in step with the state.
  bus_status_decoder u_decoder (
    .status_i (cycle_d),
    .strobe_o (dec_strobe_s),
    .read_o   (dec_read_s)
  );

  // State and latched cycle type.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cycle_q <= BS_PASSIVE;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  // T-state sequencing; the cycle type is only sampled on T1 entry.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    if (bus.cpu_clock_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!passive_s) begin
            state_d = ST_T1;
            cycle_d = status_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_T1: begin
          if (cycle_q == BS_HALT) state_d = ST_IDLE;
          else                    state_d = ST_T2;
        end
        ST_T2:   state_d = ST_T3;
        ST_T3: begin
          if (passive_s) state_d = ST_T4;
          else           state_d = ST_T3;
        end
        ST_T4: begin
          if (!passive_s) begin
            state_d = ST_T1;
            cycle_d = status_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output values for the upcoming state; a held state recomputes the held values.
  always_comb begin
    ale_d      = 1'b0;
    dtr_d      = 1'b1;
    den_d      = 1'b0;
    strobe_n_d = '1;
    case (state_d)
      ST_T1: begin
        ale_d = 1'b1;
        dtr_d = ~dec_read_s;
      end
      ST_T2: begin
        dtr_d = ~dec_read_s;
        den_d = 1'b1;
        if (dec_read_s || ADVANCED_WRITE) strobe_n_d = ~dec_strobe_s;
        else                              strobe_n_d = '1;
      end
      ST_T3: begin
        dtr_d      = ~dec_read_s;
        den_d      = 1'b1;
        strobe_n_d = ~dec_strobe_s;
      end
      default: begin
        ale_d = 1'b0;
      end
    endcase
    if ((state_d == ST_T1) && (state_q != ST_T1)) halted_d = (cycle_d == BS_HALT);
    else                                          halted_d = halted_q;
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ale_q      <= 1'b0;
      dtr_q      <= 1'b1;
      den_q      <= 1'b0;
      halted_q   <= 1'b0;
      strobe_n_q <= '1;
    end else begin
      ale_q      <= ale_d;
      dtr_q      <= dtr_d;
      den_q      <= den_d;
      halted_q   <= halted_d;
      strobe_n_q <= strobe_n_d;
    end
  end

  // A DMA master owning the bus masks the commands without disturbing the sequence.
  assign bus.address_latch_enable    = ale_q;
  assign bus.data_bus_direction      = dtr_q;
  assign bus.data_enable             = den_q;
  assign bus.halted                  = halted_q;
  assign bus.io_read_n               = strobe_n_q[STB_IOR]  | bus.address_enable_n;
  assign bus.io_write_n              = strobe_n_q[STB_IOW]  | bus.address_enable_n;
  assign bus.memory_read_n           = strobe_n_q[STB_MEMR] | bus.address_enable_n;
  assign bus.memory_write_n          = strobe_n_q[STB_MEMW] | bus.address_enable_n;
  assign bus.interrupt_acknowledge_n = strobe_n_q[STB_INTA] | bus.address_enable_n;

endmodule

// File: tb/tb_bus_command_controller.sv
// Drives two controllers (normal and advanced write) with directed and random
// status streams and compares every cycle against a behavioural bus model.
module tb_bus_command_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en_s;
  logic [2:0] st_s;
  logic       aen_s;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Model: position in the bus cycle (0 idle, 1..4 = T1..T4), cycle code, halt flag.
  int         m_t;
  logic [2:0] m_ct;
  logic       m_halted;

  localparam logic [8:0] RESET_VEC = 9'b0_1_0_11111_0;

  bus_command_controller_if bus0 ();
  bus_command_controller_if bus1 ();

  assign bus0.cpu_clock_en     = en_s;
  assign bus0.processor_status = st_s;
  assign bus0.address_enable_n = aen_s;
  assign bus1.cpu_clock_en     = en_s;
  assign bus1.processor_status = st_s;
  assign bus1.address_enable_n = aen_s;

  bus_command_controller #(.ADVANCED_WRITE(1'b0)) dut0 (
    .clock (clock), .reset_n (reset_n), .bus (bus0));
  bus_command_controller #(.ADVANCED_WRITE(1'b1)) dut1 (
    .clock (clock), .reset_n (reset_n), .bus (bus1));

  // {ALE, DT/R, DEN, IOR_n, IOW_n, MEMR_n, MEMW_n, INTA_n, halted}
  wire [8:0] obs0 = {bus0.address_latch_enable, bus0.data_bus_direction, bus0.data_enable,
                     bus0.io_read_n, bus0.io_write_n, bus0.memory_read_n,
                     bus0.memory_write_n, bus0.interrupt_acknowledge_n, bus0.halted};
  wire [8:0] obs1 = {bus1.address_latch_enable, bus1.data_bus_direction, bus1.data_enable,
                     bus1.io_read_n, bus1.io_write_n, bus1.memory_read_n,
                     bus1.memory_write_n, bus1.interrupt_acknowledge_n, bus1.halted};

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_rd(input logic [2:0] s);
    return (s == 3'b000) || (s == 3'b001) || (s == 3'b100) || (s == 3'b101);
  endfunction

  function automatic logic [8:0] expected(input logic aw, input logic aen);
    logic       act;
    logic [4:0] stb;
    logic       ale, dtr, den;
    act = !aen && ((m_t == 3) || ((m_t == 2) && (is_rd(m_ct) || aw)));
    stb = 5'b11111;
    if (act) begin
      case (m_ct)
        3'b000:         stb[0] = 1'b0;
        3'b001:         stb[4] = 1'b0;
        3'b010:         stb[3] = 1'b0;
        3'b100, 3'b101: stb[2] = 1'b0;
        3'b110:         stb[1] = 1'b0;
        default:        stb    = 5'b11111;
      endcase
    end
    ale = (m_t == 1);
    dtr = (m_t >= 1 && m_t <= 3) ? !is_rd(m_ct) : 1'b1;
    den = (m_t == 2) || (m_t == 3);
    return {ale, dtr, den, stb, m_halted};
  endfunction

  task automatic model_reset();
    m_t      = 0;
    m_ct     = 3'b111;
    m_halted = 1'b0;
  endtask

  task automatic model_start(input logic [2:0] st);
    m_t      = 1;
    m_ct     = st;
    m_halted = (st == 3'b011);
  endtask

  task automatic model_clock(input logic [2:0] st);
    case (m_t)
      0: if (st != 3'b111) model_start(st);
      1: m_t = (m_ct == 3'b011) ? 0 : 2;
      2: m_t = 3;
      3: if (st == 3'b111) m_t = 4;
      4: if (st != 3'b111) model_start(st); else m_t = 0;
      default: m_t = 0;
    endcase
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic en, input logic aen);
    st_s  = st;
    en_s  = en;
    aen_s = aen;
    @(posedge clock);
    if (en) model_clock(st);
    #1;
    check_eq({tag, "_aw0"}, obs0, expected(1'b0, aen));
    check_eq({tag, "_aw1"}, obs1, expected(1'b1, aen));
  endtask

  task automatic seq(input string tag, input logic [2:0] st, input int n,
                     input logic en, input logic aen);
    for (int i = 0; i < n; i++) step(tag, st, en, aen);
  endtask

  initial begin
    reset_n = 1'b0;
    en_s    = 1'b1;
    st_s    = 3'b111;
    aen_s   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_aw0", obs0, RESET_VEC);
    check_eq("reset_aw1", obs1, RESET_VEC);
    reset_n = 1'b1;

    seq("memrd", 3'b101, 3, 1'b1, 1'b0);
    seq("memrd", 3'b111, 3, 1'b1, 1'b0);
    seq("iowr",  3'b010, 3, 1'b1, 1'b0);
    seq("iowr",  3'b111, 3, 1'b1, 1'b0);
    seq("wait",  3'b001, 6, 1'b1, 1'b0);
    seq("wait",  3'b111, 3, 1'b1, 1'b0);
    seq("b2b",   3'b100, 3, 1'b1, 1'b0);
    seq("b2b",   3'b111, 1, 1'b1, 1'b0);
    seq("b2b",   3'b110, 3, 1'b1, 1'b0);
    seq("b2b",   3'b111, 3, 1'b1, 1'b0);
    seq("halt",  3'b011, 1, 1'b1, 1'b0);
    seq("halt",  3'b111, 2, 1'b1, 1'b0);
    seq("inta",  3'b000, 3, 1'b1, 1'b0);
    seq("inta",  3'b111, 3, 1'b1, 1'b0);
    seq("aen",   3'b110, 3, 1'b1, 1'b1);
    seq("aen",   3'b110, 1, 1'b1, 1'b0);
    seq("aen",   3'b111, 3, 1'b1, 1'b0);
    seq("cken",  3'b101, 1, 1'b1, 1'b0);
    seq("cken",  3'b011, 3, 1'b0, 1'b0);
    seq("cken",  3'b101, 3, 1'b1, 1'b0);
    seq("cken",  3'b111, 2, 1'b0, 1'b0);
    seq("cken",  3'b111, 3, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a read's T3.
    seq("rst", 3'b101, 3, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_aw0", obs0, RESET_VEC);
    check_eq("rst_async_aw1", obs1, RESET_VEC);
    model_reset();
    @(posedge clock);
    #1;
    check_eq("rst_hold_aw0", obs0, RESET_VEC);
    check_eq("rst_hold_aw1", obs1, RESET_VEC);
    reset_n = 1'b1;
    seq("rst", 3'b111, 2, 1'b1, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      step("rand", st, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
